// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared constants, the stage-count helper and the stage register layout
// for pipelined_chunk_adder.
//   PIPE_ADDER_WIDTH / PIPE_ADDER_CHUNK : default operand width and bits per stage
//   stages(width, chunk)                : number of pipeline stages (width / chunk)
//   pipe_stage_t                        : one stage register at the default width. The top
//                                         declares the same layout at its own WIDTH.
package pipe_adder_pkg;

   localparam int unsigned PIPE_ADDER_WIDTH = 16;
   localparam int unsigned PIPE_ADDER_CHUNK = 4;

   function automatic int unsigned stages(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

   typedef struct packed {
      logic                        valid;
      logic                        carry;
      logic [PIPE_ADDER_WIDTH-1:0] psum;  // sum chunks already produced
      logic [PIPE_ADDER_WIDTH-1:0] opa;   // operand chunks not yet added
      logic [PIPE_ADDER_WIDTH-1:0] opb;
   } pipe_stage_t;

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: CHUNK-bit combinational ripple-carry adder built from full adders.
//   a, b : operand chunks
//   cin  : carry into bit 0
//   s    : sum chunk
//   cout : carry out of bit CHUNK-1
//   cmsb : carry into bit CHUNK-1 (signed-overflow detection)
module chunk_adder #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   always_comb begin
      logic c;
      c    = cin;
      s    = '0;
      cmsb = cin;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) cmsb = c;
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder: sum = a + b + cin over WIDTH bits, split into CHUNK-bit ripple
// segments with one register stage per segment; one add per clock behind valid/ready.
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready is combinational)
//   a, b, cin            : operands and carry-in
//   out_valid / out_ready: output handshake
//   sum, cout            : registered result and carry out of bit WIDTH-1
//   ovf                  : registered signed overflow, only when PIPE_ADDER_OVF_EN is defined
module pipelined_chunk_adder
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH = PIPE_ADDER_WIDTH,
   parameter int unsigned CHUNK = PIPE_ADDER_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int unsigned STAGES = stages(WIDTH, CHUNK);

   if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("pipelined_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   typedef struct packed {
      logic             valid;
      logic             carry;
      logic [WIDTH-1:0] psum;
      logic [WIDTH-1:0] opa;
      logic [WIDTH-1:0] opb;
   } stage_t;

   stage_t           st_q  [STAGES];
   stage_t           st_in [STAGES];  // what each stage sees from its predecessor
   stage_t           st_d  [STAGES];
   logic [CHUNK-1:0] cs    [STAGES];
   logic             co    [STAGES];
`ifdef PIPE_ADDER_OVF_EN
   logic             cm    [STAGES];
`else
   logic             cm_unused [STAGES];
`endif

   logic en;

   // Whole pipeline advances together; a held result freezes everything behind it.
   assign out_valid = st_q[STAGES-1].valid;
   assign en        = !out_valid || out_ready;
   assign in_ready  = en;

   always_comb begin
      st_in[0]       = '0;
      st_in[0].valid = in_valid;
      st_in[0].carry = cin;
      st_in[0].opa   = a;
      st_in[0].opb   = b;
      for (int k = 1; k < STAGES; k++) st_in[k] = st_q[k-1];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      chunk_adder #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a    (st_in[k].opa[k*CHUNK +: CHUNK]),
         .b    (st_in[k].opb[k*CHUNK +: CHUNK]),
         .cin  (st_in[k].carry),
         .s    (cs[k]),
         .cout (co[k]),
`ifdef PIPE_ADDER_OVF_EN
         .cmsb (cm[k])
`else
         .cmsb (cm_unused[k])
`endif
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         st_d[k]                          = st_in[k];
         st_d[k].psum[k*CHUNK +: CHUNK]   = cs[k];
         st_d[k].carry                    = co[k];
      end
   end

   // Data only loads behind a valid item, so bubbles never disturb the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
      end else if (en) begin
         for (int k = 0; k < STAGES; k++) begin
            st_q[k].valid <= st_d[k].valid;
            if (st_d[k].valid) begin
               st_q[k].carry <= st_d[k].carry;
               st_q[k].psum  <= st_d[k].psum;
               st_q[k].opa   <= st_d[k].opa;
               st_q[k].opb   <= st_d[k].opb;
            end
         end
      end
   end

   assign sum  = st_q[STAGES-1].psum;
   assign cout = st_q[STAGES-1].carry;

`ifdef PIPE_ADDER_OVF_EN
   logic ovf_q;

   // Final stage's MSB carry-in is the carry into bit WIDTH-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (en && st_in[STAGES-1].valid) begin
         ovf_q <= cm[STAGES-1] ^ co[STAGES-1];
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
module tb_pipelined_chunk_adder;

   localparam int unsigned D = 4;  // stages of the CHUNK=4 instance

   logic        clk = 1'b0;
   logic        rst, in_valid, cin, out_ready, one;
   logic [15:0] a, b;
   logic        in_ready, out_valid, cout;
   logic        in_ready1, out_valid1, cout1;
   logic [15:0] sum, sum1;
`ifdef PIPE_ADDER_OVF_EN
   logic        ovf, ovf1;
`endif

   int n_pass = 0;
   int n_total = 0;

   // Reference model: expected result per pipeline slot, plus the 1-stage instance.
   logic        mv [D];
   logic [17:0] mr [D];
   logic        m1v;
   logic [17:0] m1r;

   always #5 clk = ~clk;

   pipelined_chunk_adder #(
      .WIDTH (16),
      .CHUNK (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
`ifdef PIPE_ADDER_OVF_EN
      .ovf       (ovf),
`endif
      .cout      (cout)
   );

   pipelined_chunk_adder #(
      .WIDTH (16),
      .CHUNK (16)
   ) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid1),
      .out_ready (one),
      .sum       (sum1),
`ifdef PIPE_ADDER_OVF_EN
      .ovf       (ovf1),
`endif
      .cout      (cout1)
   );

   // {ovf, cout, sum} from plain arithmetic
   function automatic logic [17:0] calc(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
      logic [16:0] full;
      logic        ov;
      full = {1'b0, x} + {1'b0, y} + {16'b0, c};
      ov   = (x[15] == y[15]) && (full[15] != x[15]);
      return {ov, full[16], full[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic ordy, input logic irst, output logic acc);
      logic        en;
      logic [17:0] r;
      rst = irst; in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
      en  = !mv[D-1] || ordy;
      #1;
      if (!irst) begin
         chk("in_ready", in_ready, en);
         chk("in_ready1", in_ready1, 1'b1);
      end
      acc = iv && en && !irst;
      r   = calc(ia, ib, ic);
      @(posedge clk);
      if (irst) begin
         for (int k = 0; k < D; k++) begin mv[k] = 1'b0; mr[k] = '0; end
         m1v = 1'b0; m1r = '0;
      end else begin
         if (en) begin
            for (int k = D - 1; k > 0; k--) begin
               if (mv[k-1]) mr[k] = mr[k-1];
               mv[k] = mv[k-1];
            end
            mv[0] = acc;
            if (acc) mr[0] = r;
         end
         m1v = iv;
         if (iv) m1r = r;
      end
      #1;
      chk("out_valid", out_valid, mv[D-1]);
      chk("sum", sum, mr[D-1][15:0]);
      chk("cout", cout, mr[D-1][16]);
      chk("out_valid1", out_valid1, m1v);
      chk("sum1", sum1, m1r[15:0]);
      chk("cout1", cout1, m1r[16]);
`ifdef PIPE_ADDER_OVF_EN
      chk("ovf", ovf, mr[D-1][17]);
      chk("ovf1", ovf1, m1r[17]);
`endif
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
   endtask

   initial begin
      logic        acc;
      logic [15:0] pa, pb;
      logic        pc, pending, ordy;
      one = 1'b1;
      for (int k = 0; k < D; k++) begin mv[k] = 1'b0; mr[k] = '0; end
      m1v = 1'b0; m1r = '0;

      // Reset
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, acc);
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, acc);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sum", sum, 16'h0);
      idle(1);

      // Basic add, 4-cycle latency, single-cycle out_valid
      cycle(1'b1, 16'h1234, 16'h0FCC, 1'b0, 1'b1, 1'b0, acc);
      chk("basic_sum1", sum1, 16'h2200);
      idle(2);
      chk("basic_early", out_valid, 1'b0);
      idle(1);
      chk("basic_valid", out_valid, 1'b1);
      chk("basic_sum", sum, 16'h2200);
      idle(1);
      chk("basic_single", out_valid, 1'b0);
      idle(2);

      // Full carry ripple and signed overflow
      cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, acc);
      idle(3);
      chk("ripple_sum", sum, 16'h0000);
      chk("ripple_cout", cout, 1'b1);
      cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, acc);
      idle(3);
      chk("ovf_sum", sum, 16'h8000);
      chk("ovf_cout", cout, 1'b0);
`ifdef PIPE_ADDER_OVF_EN
      chk("ovf_flag", ovf, 1'b1);
`endif
      idle(2);

      // Streaming: 8 back-to-back
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0, acc);
      idle(5);

      // Backpressure: out_ready low for 3 cycles mid-stream, inputs held until accepted
      pending = 1'b0; pa = '0; pb = '0; pc = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (!pending) begin
            pa = 16'($urandom); pb = 16'($urandom); pc = 1'($urandom_range(0, 1));
            pending = 1'b1;
         end
         ordy = !(c >= 6 && c <= 8);
         cycle(1'b1, pa, pb, pc, ordy, 1'b0, acc);
         if (c >= 6 && c <= 8) chk("bp_in_ready", in_ready, 1'b0);
         if (acc) pending = 1'b0;
      end
      idle(5);

      // Random valid / ready traffic
      pending = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (!pending) begin
            pa = 16'($urandom); pb = 16'($urandom); pc = 1'($urandom_range(0, 1));
            pending = 1'($urandom_range(0, 1));
         end
         cycle(pending, pa, pb, pc, 1'($urandom_range(0, 3) != 0), 1'b0, acc);
         if (acc) pending = 1'b0;
      end
      idle(5);

      // Reset with 3 items in flight; none may ever appear
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b0, acc);
      cycle(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b1, acc);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_sum", sum, 16'h0);
      chk("mid_rst_cout", cout, 1'b0);
      idle(6);

      // Bubbles: alternating in_valid
      for (int i = 0; i < 10; i++)
         cycle(1'(i % 2 == 0), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               1'b1, 1'b0, acc);
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipelined_chunk_adder.md
# pipelined_chunk_adder

Parametrised, pipelined carry-propagate adder computing `sum = a + b + cin` over `WIDTH` bits. The add is split into `CHUNK`-bit ripple segments, with one register stage per segment. It sustains one addition per clock behind a valid/ready handshake on both sides. It is the datapath adder for wider arithmetic blocks where a single full-width ripple chain would not close timing.

## Interface
- `WIDTH`, 16: operand and sum width in bits.
- `CHUNK`, 4: bits added per pipeline stage. `WIDTH % CHUNK` must be 0, otherwise elaboration fails with an error. `STAGES = WIDTH/CHUNK`, and `STAGES = 1` is legal.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands present.
- `in_ready` output 1: adder can accept this cycle.
- `a` input `WIDTH`: operand A, unsigned or two's complement.
- `b` input `WIDTH`: operand B.
- `cin` input 1: carry-in.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts result.
- `sum` output `WIDTH`: `(a + b + cin) mod 2^WIDTH`.
- `cout` output 1: carry out of bit `WIDTH-1`.
- `ovf` output 1: signed overflow. Present only with `PIPE_ADDER_OVF_EN`.

## Operation
- **Stage k (0..STAGES-1):**
  - Adds chunk k of the skewed operands plus the carry registered by stage k-1. Stage 0 uses `cin`.
  - Stores the chunk-k sum, the carry-out, the already-computed lower sum chunks, and the not-yet-added upper operand chunks.
- **Stall:** `en = !out_valid || out_ready`, and `in_ready = en` (combinational).
  - When `en=0`, every stage register, valid bit and carry holds.
  - When `en=1`, all stages advance.
- **Valid bits:** stage 0 valid loads `in_valid & en`.
  - If `in_valid=0` while `en=1`, a bubble (valid=0) enters the pipeline. Bubble data is don't-care, but the outputs must not glitch while `out_valid=0`.
  - There is no bubble collapsing. Throughput is 1 result/cycle when `out_ready` is held high.
- **Arithmetic:** unsigned modular.
  - `cout` is the final stage's chunk carry.
  - With 0xFFFF+0x0001, the carry ripples across stage boundaries one stage per cycle. The result is still correct after `STAGES` cycles.
- **Reset:**
  - All valid bits, `sum`, `cout` and `ovf` go to 0 on the next edge.
  - In-flight operations are discarded.
  - `in_ready` reads 1 in the cycle after reset, because `out_valid=0`.
- **No FSM:** control is the per-stage valid chain plus the global enable.

## Timing
- Latency is `STAGES` cycles. If the handshake `in_valid && in_ready` occurs at edge t, `out_valid` rises after edge t+STAGES-1, with `sum` and `cout` valid.
- Outputs are registered. `in_ready` is the only combinational path, from `out_ready` and `out_valid`.
- **Simultaneous events:**
  - A result handshake and a new input in the same cycle are both accepted.
  - `rst` overrides `en` and `in_valid`.
- **Backpressure:** `out_valid` with `!out_ready` holds the whole pipeline and `in_ready=0`. Up to `STAGES` items are held without loss.
- **`STAGES = 1`:** single register, 1-cycle latency, same handshake.

## Configuration
- **`PIPE_ADDER_OVF_EN` defined:**
  - Adds the `ovf` port.
  - The final stage computes `ovf = carry into bit WIDTH-1 XOR cout` and registers it alongside `sum`.
  - `ovf` resets to 0 and holds on stall.
- **`PIPE_ADDER_OVF_EN` undefined:** no `ovf` port and no overflow logic. All other behaviour is identical.

## Structure
- **Package `pipe_adder_pkg`:**
  - Default `WIDTH`/`CHUNK` constants.
  - Stage-count function `stages(WIDTH, CHUNK)`.
  - Stage register struct typedef holding valid, carry, partial sum and remaining operands.
- **Sub-module `chunk_adder`:** `CHUNK`-bit combinational ripple adder built from full adders, with `a`, `b`, `cin`, `s` and `cout`. It exposes the MSB carry-in for the overflow calculation. It is instantiated once per stage via generate.

## Test plan
Test configuration: `WIDTH=16`, `CHUNK=4`, `PIPE_ADDER_OVF_EN` defined.
- **Basic add:** 0x1234 + 0x0FCC, `cin=0`, `out_ready=1` -> after 4 cycles `sum=0x2200`, `cout=0`, `ovf=0`, `out_valid` high for exactly 1 cycle.
- **Full carry ripple:** 0xFFFF + 0x0000, `cin=1` -> `sum=0x0000`, `cout=1`; 0x7FFF + 0x0001 -> `sum=0x8000`, `ovf=1`, `cout=0`.
- **Streaming:** 8 back-to-back random pairs, `in_valid` held high -> 8 consecutive results matching the model, in order, no gaps, first result 4 cycles after the first handshake.
- **Backpressure:** during a stream, drop `out_ready` for 3 cycles -> `in_ready=0` and outputs stable for those 3 cycles, no loss or duplication, order preserved.
- **Reset mid-operation:** assert `rst` for 1 cycle with 3 items in flight -> `out_valid=0`, `sum=0`, `cout=0` next cycle, `in_ready=1`, and none of the discarded results ever appear.
- **Bubbles and `STAGES=1`:** alternate `in_valid` 1/0 -> results alternate with idle cycles. Repeat with `CHUNK=16` -> 1-cycle latency, same results.
